// File: rtl/pc_update_unit_if.sv
// Bus between the fetch datapath (adders, branch decode, memory stall) and the PC update unit.
// PC_BNE_EN adds the bne strobe.
interface pc_update_unit_if;
  logic [31:0] pcadder;
  logic [31:0] target;
  logic        jump;
  logic        branch;
  logic        zero;
`ifdef PC_BNE_EN
  logic        bne;
`endif
  logic        busywait;
  logic [31:0] pc;
  logic        pc_valid;
  logic        redirect;

  modport master (
    output pcadder, target, jump, branch, zero, busywait,
`ifdef PC_BNE_EN
    output bne,
`endif
    input  pc, pc_valid, redirect
  );

  modport slave (
    input  pcadder, target, jump, branch, zero, busywait,
`ifdef PC_BNE_EN
    input  bne,
`endif
    output pc, pc_valid, redirect
  );
endinterface

// File: rtl/pc_update_unit.sv
// Program counter register with next-PC select, stall hold and deferred redirect.
// PC_BNE_EN adds branch-if-not-equal to the taken decision.
module pc_update_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES  = 1
) (
  input logic             clk,
  input logic             rst_n,
  pc_update_unit_if.slave bus
);

  localparam logic [3:0] BootLast = 4'(BOOT_CYCLES);

  typedef enum logic [1:0] {StBoot, StRun, StStall} state_e;

  state_e      state_q;
  logic [3:0]  boot_cnt_q;
  logic        pend_valid_q;
  logic [31:0] pend_pc_q;
  logic [31:0] pc_q;
  logic        pc_valid_q;
  logic        redirect_q;
  logic        taken;

  always_comb begin
    taken = bus.jump | (bus.branch & bus.zero);
`ifdef PC_BNE_EN
    taken = taken | (bus.bne & ~bus.zero);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StBoot;
      boot_cnt_q   <= 4'd0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'd0;
      pc_q         <= RESET_VECTOR;
      pc_valid_q   <= 1'b0;
      redirect_q   <= 1'b0;
    end else begin
      case (state_q)
        StBoot: begin
          redirect_q <= 1'b0;
          boot_cnt_q <= boot_cnt_q + 4'd1;
          if (boot_cnt_q + 4'd1 == BootLast) begin
            state_q    <= StRun;
            pc_valid_q <= 1'b1;
          end
        end
        StRun: begin
          if (bus.busywait) begin
            redirect_q <= 1'b0;
            if (taken) begin
              pend_pc_q    <= bus.target;
              pend_valid_q <= 1'b1;
            end
            state_q <= StStall;
          end else begin
            pc_q       <= taken ? bus.target : bus.pcadder;
            redirect_q <= taken;
          end
        end
        StStall: begin
          if (bus.busywait) begin
            redirect_q <= 1'b0;
            // First taken decision during a stall wins; later ones are dropped.
            if (taken && !pend_valid_q) begin
              pend_pc_q    <= bus.target;
              pend_valid_q <= 1'b1;
            end
          end else begin
            pc_q         <= pend_valid_q ? pend_pc_q : (taken ? bus.target : bus.pcadder);
            redirect_q   <= pend_valid_q | taken;
            pend_valid_q <= 1'b0;
            state_q      <= StRun;
          end
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = pc_valid_q;
  assign bus.redirect = redirect_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Randomized bench for pc_update_unit against a behavioural next-PC model.
// Define PC_BNE_EN to also exercise the bne strobe.
module tb_pc_update_unit;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int unsigned BC = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_update_unit_if bus();

  pc_update_unit #(
    .RESET_VECTOR(RV),
    .BOOT_CYCLES (BC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: PC, outputs, boot cycles left and a queue holding at most one deferred target.
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_redir;
  int          m_boot_left;
  logic [31:0] m_pend[$];
  logic        in_bne;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RV;
    m_valid = 1'b0;
    m_redir = 1'b0;
    m_pend.delete();
    m_boot_left = BC;
  endtask

  task automatic model_step();
    logic tk;
    tk = bus.jump | (bus.branch & bus.zero);
`ifdef PC_BNE_EN
    tk = tk | (in_bne & ~bus.zero);
`endif
    if (m_boot_left > 0) begin
      m_boot_left--;
      if (m_boot_left == 0) m_valid = 1'b1;
      m_redir = 1'b0;
    end else if (bus.busywait) begin
      m_redir = 1'b0;
      if (tk && m_pend.size() == 0) m_pend.push_back(bus.target);
    end else if (m_pend.size() != 0) begin
      m_pc = m_pend.pop_front();
      m_redir = 1'b1;
    end else begin
      m_pc = tk ? bus.target : bus.pcadder;
      m_redir = tk;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_eq("pc", bus.pc, m_pc);
    check_eq("pc_valid", {31'd0, bus.pc_valid}, {31'd0, m_valid});
    check_eq("redirect", {31'd0, bus.redirect}, {31'd0, m_redir});
  endtask

  task automatic drive(input logic j, input logic b, input logic z, input logic n,
                       input logic bw, input logic [31:0] tgt, input logic [31:0] pca);
    bus.jump = j;
    bus.branch = b;
    bus.zero = z;
    bus.busywait = bw;
    bus.target = tgt;
    bus.pcadder = pca;
    in_bne = n;
`ifdef PC_BNE_EN
    bus.bne = n;
`endif
  endtask

  // One cycle with pcadder supplied as PC+4 from the model's view of PC.
  task automatic go(input logic j, input logic b, input logic z, input logic n,
                    input logic bw, input logic [31:0] tgt);
    drive(j, b, z, n, bw, tgt, m_pc + 32'd4);
    cycle();
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    model_reset();

    // Reset, boot and sequential fetch.
    repeat (2) cycle();
    check_eq("t1_rst_pc", bus.pc, 32'h0);
    rst_n = 1'b1;
    #1 check_eq("t1_valid_low", {31'd0, bus.pc_valid}, 32'd0);
    go(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t1_boot_pc", bus.pc, 32'h0);
    check_eq("t1_valid_high", {31'd0, bus.pc_valid}, 32'd1);
    go(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t1_pc4", bus.pc, 32'h4);
    go(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t1_pc8", bus.pc, 32'h8);
    go(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t1_pcc", bus.pc, 32'hc);

    // BEQ taken and not taken from PC=8.
    go(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8);
    go(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20);
    check_eq("t2_taken_pc", bus.pc, 32'h20);
    check_eq("t2_taken_redir", {31'd0, bus.redirect}, 32'd1);
    go(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8);
    go(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20);
    check_eq("t2_nt_pc", bus.pc, 32'hc);
    check_eq("t2_nt_redir", {31'd0, bus.redirect}, 32'd0);

    // Jump raised during a 3-cycle stall is deferred, plus a later taken that must be dropped.
    go(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10);
    go(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    check_eq("t3_hold1", bus.pc, 32'h10);
    go(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h99);
    check_eq("t3_hold2", bus.pc, 32'h10);
    go(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check_eq("t3_hold3", bus.pc, 32'h10);
    go(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t3_resume_pc", bus.pc, 32'h40);
    check_eq("t3_resume_redir", {31'd0, bus.redirect}, 32'd1);
    go(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t3_pulse_end", {31'd0, bus.redirect}, 32'd0);

    // Reset mid-stall with a pending redirect.
    go(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
    #2 rst_n = 1'b0;
    #1 check_eq("t4_async_pc", bus.pc, RV);
    check_eq("t4_async_valid", {31'd0, bus.pc_valid}, 32'd0);
    model_reset();
    cycle();
    rst_n = 1'b1;
    repeat (4) go(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t4_seq_pc", bus.pc, 32'hc);

    // Wrap from the top of the address space.
    go(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hffff_fffc);
    go(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t5_wrap_pc", bus.pc, 32'h0);
    check_eq("t5_wrap_redir", {31'd0, bus.redirect}, 32'd0);

`ifdef PC_BNE_EN
    go(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80);
    check_eq("t6_bne_taken", bus.pc, 32'h80);
    go(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200);
    check_eq("t6_bne_nt", bus.pc, 32'h84);
`endif

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(79) == 0) begin
        #2 rst_n = 1'b0;
        #1 check_eq("rnd_rst_pc", bus.pc, RV);
        model_reset();
        cycle();
        rst_n = 1'b1;
      end else begin
        drive($urandom_range(6) == 0, $urandom_range(2) == 0, $urandom_range(1) == 1,
              $urandom_range(3) == 0, $urandom_range(9) < 3, $urandom,
              ($urandom_range(3) == 0) ? 32'($urandom) : m_pc + 32'd4);
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
